// File: rtl/cdp1861_dma_host.sv
// cdp1861_dma_host: 1802-style bus sequencer serving CDP1861 display DMA and interrupts.
// Emits TPA/TPB/SC machine-cycle timing, runs DMA-out reads at R0 (post-increment),
// and acknowledges display interrupts with an interrupt cycle.
// Optional: define CDP1861_HOST_DMAIN_EN to add a DMA-in path (DMAI_n, dma_in_data, mem_wr).
module cdp1861_dma_host #(
  parameter int unsigned CYCLE_LEN = 8,
  parameter logic [15:0] R0_RESET  = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DMAO_n,
  input  logic        INT_n,
  input  logic        r0_load,
  input  logic [15:0] r0_value,
  input  logic        ie_set,
  input  logic [7:0]  mem_data,
`ifdef CDP1861_HOST_DMAIN_EN
  input  logic        DMAI_n,
  input  logic [7:0]  dma_in_data,
  output logic        mem_wr,
`endif
  output logic        TPA,
  output logic        TPB,
  output logic [1:0]  SC,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  DataOut,
  output logic        int_ack,
  output logic [15:0] r0,
  output logic        ie
);

  localparam int unsigned PH_W    = 4;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLE_LEN - 1);
  localparam logic [PH_W-1:0] PH_TPA  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_RD   = PH_W'(2);
  localparam logic [PH_W-1:0] PH_CAP  = PH_W'(3);
  localparam logic [PH_W-1:0] PH_TPB  = PH_W'(6);

  // State encoding doubles as the SC code driven to the display.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b10,
    ST_DMA   = 2'b01,
    ST_INTR  = 2'b11
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;
  logic            wrap;
  logic            rd_slot;
  logic            dma_req;
  logic            dma_pend;
  logic            int_pend;
`ifdef CDP1861_HOST_DMAIN_EN
  logic            dmai_pend;
  logic            dma_in;
`endif

  assign SC = 2'(state);

  // Phase advance and next machine-cycle selection (DMA beats interrupt).
  always_comb begin
    wrap      = (ph == PH_LAST);
    ph_nxt    = wrap ? '0 : ph + PH_W'(1);
    rd_slot   = (state == ST_DMA) && (ph_nxt == PH_RD);
`ifdef CDP1861_HOST_DMAIN_EN
    dma_req   = dma_pend | dmai_pend;
`else
    dma_req   = dma_pend;
`endif
    state_nxt = state;
    case (state)
      ST_FETCH: state_nxt = ST_EXEC;
      ST_INTR:  state_nxt = ST_FETCH;
      default: begin
        if (dma_req)             state_nxt = ST_DMA;
        else if (int_pend && ie) state_nxt = ST_INTR;
        else                     state_nxt = ST_FETCH;
      end
    endcase
  end

  // Cycle sequencer with registered timing, bus and register outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ph        <= '0;
      state     <= ST_FETCH;
      TPA       <= 1'b0;
      TPB       <= 1'b0;
      dma_pend  <= 1'b0;
      int_pend  <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      DataOut   <= '0;
      int_ack   <= 1'b0;
      r0        <= R0_RESET;
      ie        <= 1'b1;
`ifdef CDP1861_HOST_DMAIN_EN
      dmai_pend <= 1'b0;
      dma_in    <= 1'b0;
      mem_wr    <= 1'b0;
`endif
    end else begin
      ph      <= ph_nxt;
      TPA     <= (ph_nxt == PH_TPA);
      TPB     <= (ph_nxt == PH_TPB);
      int_ack <= 1'b0;

      if (ph == PH_TPB) begin
        dma_pend <= ~DMAO_n;
        int_pend <= ~INT_n;
`ifdef CDP1861_HOST_DMAIN_EN
        dmai_pend <= ~DMAI_n;
`endif
      end

      if (wrap) begin
        state <= state_nxt;
`ifdef CDP1861_HOST_DMAIN_EN
        dma_in <= (state_nxt == ST_DMA) && dmai_pend;
`endif
      end

      mem_addr <= rd_slot ? r0 : '0;
`ifdef CDP1861_HOST_DMAIN_EN
      mem_rd <= rd_slot && !dma_in;
      mem_wr <= rd_slot && dma_in;
      if (wrap)
        DataOut <= '0;
      else if (rd_slot && dma_in)
        DataOut <= dma_in_data;
      else if ((state == ST_DMA) && (ph == PH_CAP) && !dma_in)
        DataOut <= mem_data;
`else
      mem_rd <= rd_slot;
      if (wrap)
        DataOut <= '0;
      else if ((state == ST_DMA) && (ph == PH_CAP))
        DataOut <= mem_data;
`endif

      // Interrupt-cycle entry clears IE; this wins over a same-clock ie_set.
      if (wrap && (state_nxt == ST_INTR)) begin
        ie      <= 1'b0;
        int_ack <= 1'b1;
      end else if (ie_set) begin
        ie <= 1'b1;
      end

      // Explicit load beats the end-of-DMA post-increment.
      if (r0_load)
        r0 <= r0_value;
      else if ((state == ST_DMA) && wrap)
        r0 <= r0 + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdp1861_dma_host.sv
// Scoreboard bench for cdp1861_dma_host: stimulus queues per-cycle expectations,
// monitors compare them when TPB, mem_rd or int_ack are presented.
module tb_cdp1861_dma_host;

  localparam int unsigned LEN = 8;
  localparam logic [15:0] R0_RST = 16'h0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        DMAO_n = 1'b1;
  logic        INT_n = 1'b1;
  logic        r0_load = 1'b0;
  logic [15:0] r0_value = 16'h0000;
  logic        ie_set = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        TPA, TPB, mem_rd, int_ack, ie;
  logic [1:0]  SC;
  logic [15:0] mem_addr, r0;
  logic [7:0]  DataOut;

  cdp1861_dma_host #(.CYCLE_LEN(LEN), .R0_RESET(R0_RST)) dut (
    .clock(clock), .reset(reset), .DMAO_n(DMAO_n), .INT_n(INT_n),
    .r0_load(r0_load), .r0_value(r0_value), .ie_set(ie_set), .mem_data(mem_data),
    .TPA(TPA), .TPB(TPB), .SC(SC), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .DataOut(DataOut), .int_ack(int_ack), .r0(r0), .ie(ie)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] sc;
    logic [7:0] dout;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          exp_acks = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          bph = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
  endtask

  // Memory returns the address LSB one clock after the read strobe.
  always @(posedge clock) if (mem_rd) mem_data <= mem_addr[7:0];

  // Reference phase position within the machine cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) bph <= 0;
    else       bph <= (bph == LEN - 1) ? 0 : bph + 1;
  end

  // Monitor: timing pulses, per-cycle SC/DataOut at TPB, DMA reads, interrupt acks.
  always @(negedge clock) begin
    if (!reset) begin
      check("tpa_phase", 32'(TPA), 32'(bph == 1));
      check("tpb_phase", 32'(TPB), 32'(bph == 6));
      if (TPB) begin
        if (exp_q.size() == 0) check("tpb_unexpected", 32'(TPB), 32'(0));
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sc_at_tpb", 32'(SC), 32'(e.sc));
          check("dout_at_tpb", 32'(DataOut), 32'(e.dout));
        end
      end
      if (mem_rd) begin
        if (addr_q.size() == 0) check("rd_unexpected", 32'(mem_rd), 32'(0));
        else begin
          check("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
          check("rd_phase", 32'(bph), 32'(2));
        end
      end
      if (int_ack) begin
        if (exp_acks == 0) check("ack_unexpected", 32'(int_ack), 32'(0));
        else begin
          exp_acks--;
          check("ack_phase", 32'(bph), 32'(0));
          check("ack_sc", 32'(SC), 32'(2'b11));
        end
      end
    end
  end

  // One machine cycle: queue expectation, hold request lines, optional strobes at given phases.
  task automatic run_cycle(input logic [1:0] sc, input logic [15:0] addr, input logic dmao,
                           input logic intn, input int load_ph, input logic [15:0] load_val,
                           input int ie_ph);
    exp_t e;
    e.sc   = sc;
    e.dout = (sc == 2'b01) ? addr[7:0] : 8'h00;
    exp_q.push_back(e);
    if (sc == 2'b01) addr_q.push_back(addr);
    if (sc == 2'b11) exp_acks++;
    DMAO_n   = dmao;
    INT_n    = intn;
    r0_value = load_val;
    for (int p = 0; p < LEN; p++) begin
      r0_load = (p == load_ph);
      ie_set  = (p == ie_ph);
      @(posedge clock); #1;
    end
    r0_load = 1'b0;
    ie_set  = 1'b0;
  endtask

  task automatic idle(input logic [1:0] sc, input logic dmao, input logic intn);
    run_cycle(sc, 16'h0000, dmao, intn, -1, 16'h0000, -1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tpa"}, 32'(TPA), 32'(0));
    check({tag, "_tpb"}, 32'(TPB), 32'(0));
    check({tag, "_sc"}, 32'(SC), 32'(0));
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_dout"}, 32'(DataOut), 32'(0));
    check({tag, "_int_ack"}, 32'(int_ack), 32'(0));
    check({tag, "_r0"}, 32'(r0), 32'(R0_RST));
    check({tag, "_ie"}, 32'(ie), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b0;

    // Idle: FETCH/EXEC alternate, no reads.
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b10, 1'b1, 1'b1);
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b10, 1'b1, 1'b1);

    // Eight-byte DMA burst from 0300.
    run_cycle(2'b00, 16'h0000, 1'b0, 1'b1, 0, 16'h0300, -1);
    idle(2'b10, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      run_cycle(2'b01, 16'h0300 + 16'(k), (k == 7), 1'b1, -1, 16'h0000, -1);
    check("r0_after_burst", 32'(r0), 32'h0308);

    // Interrupt, masked retry, re-enable, and ie_set colliding with INTR entry.
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b10, 1'b1, 1'b0);
    idle(2'b11, 1'b1, 1'b0);
    check("ie_cleared", 32'(ie), 32'(0));
    idle(2'b00, 1'b1, 1'b0);
    idle(2'b10, 1'b1, 1'b0);
    run_cycle(2'b00, 16'h0000, 1'b1, 1'b0, -1, 16'h0000, 0);
    check("ie_reenabled", 32'(ie), 32'(1));
    run_cycle(2'b10, 16'h0000, 1'b1, 1'b0, -1, 16'h0000, 7);
    check("ie_clear_wins", 32'(ie), 32'(0));
    idle(2'b11, 1'b1, 1'b1);

    // DMA and INT together: DMA first, INTR after DMAO_n releases.
    run_cycle(2'b00, 16'h0000, 1'b0, 1'b0, -1, 16'h0000, 0);
    idle(2'b10, 1'b0, 1'b0);
    run_cycle(2'b01, 16'h0308, 1'b0, 1'b0, -1, 16'h0000, -1);
    run_cycle(2'b01, 16'h0309, 1'b1, 1'b0, -1, 16'h0000, -1);
    idle(2'b11, 1'b1, 1'b1);
    check("r0_after_mixed", 32'(r0), 32'h030A);

    // R0 wrap FFFF -> 0000.
    run_cycle(2'b00, 16'h0000, 1'b1, 1'b1, 0, 16'hFFFF, -1);
    idle(2'b10, 1'b0, 1'b1);
    run_cycle(2'b01, 16'hFFFF, 1'b1, 1'b1, -1, 16'h0000, -1);
    check("r0_wrap", 32'(r0), 32'h0000);

    // Load in the increment clock wins.
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b10, 1'b0, 1'b1);
    run_cycle(2'b01, 16'h0000, 1'b1, 1'b1, 7, 16'h1234, -1);
    check("r0_load_wins", 32'(r0), 32'h1234);

    // Reset at ph=4 of a DMA cycle.
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b10, 1'b0, 1'b1);
    addr_q.push_back(16'h1234);
    DMAO_n = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    check("dma_sc_ph4", 32'(SC), 32'(2'b01));
    check("dma_dout_ph4", 32'(DataOut), 32'h34);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(2'b00, 1'b1, 1'b1);
    idle(2'b10, 1'b1, 1'b1);
    check("r0_after_rst", 32'(r0), 32'(R0_RST));

    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    check("addr_q_drained", 32'(addr_q.size()), 32'(0));
    check("acks_seen", 32'(exp_acks), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cdp1861_dma_host.md
# cdp1861_dma_host

CPU-side bus sequencer that answers the CDP1861 display controller: it generates 1802-style machine-cycle timing (TPA, TPB, SC), grants DMA-out cycles when the display pulls DMAO low, and reads display bytes from memory at R0, incrementing R0 after each byte. It also acknowledges the display's INT with an interrupt cycle. It sits between the memory/core and the `cdp1861` instance, replacing a full CPU core for display bring-up and for arbitration of display DMA.

## Interface
Parameters:
- `CYCLE_LEN`, 8: clocks per machine cycle (legal 8..15).
- `R0_RESET`, 16'h0000: R0 value after reset.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `DMAO_n`  in  1  DMA-out request from the display, active low.
- `INT_n`  in  1  interrupt request from the display, active low.
- `r0_load`  in  1  one-clock strobe; loads `r0_value` into R0.
- `r0_value`  in  16  R0 load value.
- `ie_set`  in  1  one-clock strobe; sets interrupt enable (IE).
- `mem_data`  in  8  memory read data, valid one clock after `mem_rd`.
- `TPA`  out  1  timing pulse A.
- `TPB`  out  1  timing pulse B.
- `SC`  out  2  state code: 00 fetch, 10 execute, 01 DMA, 11 interrupt.
- `mem_addr`  out  16  memory address (R0 during DMA).
- `mem_rd`  out  1  memory read strobe.
- `DataOut`  out  8  bus data to the display.
- `int_ack`  out  1  one-clock pulse on interrupt-cycle entry.
- `r0`  out  16  current R0.
- `ie`  out  1  current interrupt enable.

## Operation
- Phase counter `ph` runs 0..CYCLE_LEN-1 and wraps. The machine-cycle type is latched at wrap.
- Cycle states are FETCH, EXEC, DMA and INTR. Reset state is FETCH with `ph`=0.
- Transitions, evaluated at `ph`=CYCLE_LEN-1:
  - FETCH goes to EXEC.
  - INTR goes to FETCH.
  - EXEC or DMA: go to DMA if `dma_pend`; else go to INTR if `int_pend` and IE; else go to FETCH.
- `dma_pend` and `int_pend` are `~DMAO_n` and `~INT_n`, sampled at the TPB phase (`ph`=6). A request that first appears after TPB is seen one cycle later.
- DMA has priority over INTR. Back-to-back DMA cycles continue while DMAO_n stays low at each TPB.
- DMA cycle:
  - `mem_addr`=R0 and `mem_rd`=1 at `ph`=2.
  - `mem_data` is captured into `DataOut` at `ph`=3 and held to the end of the cycle.
  - R0 increments by 1 at `ph`=CYCLE_LEN-1, with 16-bit wrap: FFFF goes to 0000.
- INTR cycle: IE clears and `int_ack` pulses at `ph`=0. `ie_set` re-enables IE.
- Outside DMA, `mem_rd`=0 and `DataOut`=00.
- `r0_load` takes priority over the DMA increment in the same clock. `ie_set` in the INTR entry clock leaves IE=0, because clear wins.
- Reset values: TPA=0, TPB=0, SC=00, `mem_rd`=0, `mem_addr`=0000, `DataOut`=00, `int_ack`=0, `r0`=R0_RESET, `ie`=1.
- Reset mid-DMA aborts the cycle without incrementing R0.

## Timing
- TPA is high for exactly one clock, at `ph`=1. TPB is high for exactly one clock, at `ph`=6.
- SC changes only at `ph`=0 and is stable for the whole cycle, so the display sees SC=01 and TPB together in a DMA cycle.
- Memory read latency is 1 clock: address and read strobe at `ph`=2, data sampled at `ph`=3.
- `DataOut` is stable from `ph`=4 through TPB.
- From DMAO_n falling before TPB of an EXEC cycle to SC=01: the next cycle boundary, i.e. at most CYCLE_LEN-6 clocks after that TPB.
- One display line of 8 DMA bytes takes 8×CYCLE_LEN clocks of consecutive DMA cycles.

## Configuration
- Macro `CDP1861_HOST_DMAIN_EN`.
- When defined:
  - Adds ports `DMAI_n` (in, 1), `dma_in_data` (in, 8) and `mem_wr` (out, 1).
  - A DMA-in request, sampled at TPB, has priority over DMA-out.
  - The DMA-in cycle uses SC=01 and drives `mem_addr`=R0, `mem_wr`=1 at `ph`=2 with `DataOut`=`dma_in_data`.
  - R0 increments as for DMA-out.
- When undefined: these ports are absent, `mem_wr` logic is not built, and behaviour matches the base description.

## Test plan
- Reset, then run idle with DMAO_n=1 and INT_n=1 → SC alternates 00/10. TPA at `ph`=1 and TPB at `ph`=6, one clock each. `mem_rd` never asserts.
- `r0_load` with 16'h0300, then hold DMAO_n=0 for 8 cycles; memory returns the address LSB → eight SC=01 cycles. `DataOut` is 00..07 at each TPB, and `r0` ends at 16'h0308.
- INT_n=0 with IE=1 → after the next EXEC cycle, one SC=11 cycle and `int_ack` pulses once. `ie` becomes 0; a further INT_n=0 is ignored until `ie_set`.
- DMAO_n=0 and INT_n=0 together → the DMA cycles run first; the INTR cycle follows only after DMAO_n returns to 1.
- R0=FFFF, one DMA cycle → reads address FFFF, then `r0`=0000. In a separate run, `r0_load` in the increment clock → `r0` equals the loaded value.
- Assert `reset` at `ph`=4 of a DMA cycle → all outputs take their reset values immediately and `r0`=R0_RESET. After release, the first cycle is FETCH.
